// File: rtl/eth_tx_serializer_if.sv
// Byte-stream handshake and line-side signals of the 10BASE-T transmit serializer.
interface eth_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       eth_data_s;
    logic       Tx_w;
    logic       tx_busy;
    logic       tx_underrun;

    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready, eth_data_s, Tx_w, tx_busy, tx_underrun
    );
    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready, eth_data_s, Tx_w, tx_busy, tx_underrun
    );
endinterface

// File: rtl/eth_tx_serializer.sv
// 10BASE-T transmit serializer: preamble/SFD, data, zero pad, CRC-32 FCS, Manchester line
// coding at one half-bit per clock, TP_IDL tail and inter-packet gap enforcement.
module eth_tx_serializer #(
    parameter int MIN_PAYLOAD = 60,
    parameter int TPIDL_CYC   = 5,
    parameter int IPG_CYC     = 192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_tx_serializer_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_DATA     = 3'd3,
        S_PAD      = 3'd4,
        S_FCS      = 3'd5,
        S_TPIDL    = 3'd6,
        S_GAP      = 3'd7
    } state_e;

    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [7:0]  SFD_BYTE   = 8'hD5;
    localparam logic [7:0]  MIN_PAY    = 8'(MIN_PAYLOAD);
    localparam logic [15:0] TPIDL_LAST = 16'(TPIDL_CYC - 1);
    localparam logic [15:0] IPG_LOAD   = 16'(IPG_CYC);

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] tp_cnt_q, tp_cnt_d;
    logic [15:0] ipg_cnt_q, ipg_cnt_d;
    logic        eth_data_q, eth_data_d;
    logic        tx_w_q, tx_w_d;
    logic        busy_q, busy_d;
    logic        underrun_q, underrun_d;

    logic        ready_s, accept_s, serial_s, unit_end_s, cur_bit_s, next_bit_s;
    logic [5:0]  last_idx_s;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic din);
        crc_step = {1'b0, crc[31:1]} ^ ({32{crc[0] ^ din}} & CRC_POLY);
    endfunction

    // Bit carried by the current bit period; the FCS goes out as the complement of the CRC.
    function automatic logic line_bit(input state_e st, input logic [5:0] idx,
                                      input logic [7:0] data, input logic [31:0] crc);
        logic [7:0]  sfd_sh;
        logic [7:0]  data_sh;
        logic [31:0] crc_sh;
        sfd_sh  = SFD_BYTE >> idx;
        data_sh = data >> idx;
        crc_sh  = crc >> idx;
        case (st)
            S_PREAMBLE: line_bit = ~idx[0];
            S_SFD:      line_bit = sfd_sh[0];
            S_DATA:     line_bit = data_sh[0];
            S_FCS:      line_bit = ~crc_sh[0];
            default:    line_bit = 1'b0;
        endcase
    endfunction

    assign ready_s  = ((state_q == S_IDLE) && (ipg_cnt_q == 16'd0)) ||
                      ((state_q == S_DATA) && (bit_cnt_q == 6'd7) && phase_q && !last_q);
    assign accept_s = bus.tx_valid & ready_s;

    assign bus.tx_ready    = ready_s;
    assign bus.eth_data_s  = eth_data_q;
    assign bus.Tx_w        = tx_w_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_underrun = underrun_q;

    // Next-state logic: bit/phase sequencing, CRC accumulation and frame state transitions.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        byte_d     = byte_q;
        last_d     = last_q;
        tp_cnt_d   = tp_cnt_q;
        ipg_cnt_d  = ipg_cnt_q;
        underrun_d = 1'b0;
        serial_s   = state_q inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS};
        cur_bit_s  = line_bit(state_q, bit_cnt_q, byte_q, crc_q);

        case (state_q)
            S_PREAMBLE: last_idx_s = 6'd55;
            S_FCS:      last_idx_s = 6'd31;
            default:    last_idx_s = 6'd7;
        endcase
        unit_end_s = phase_q && (bit_cnt_q == last_idx_s);

        if (serial_s) begin
            phase_d = ~phase_q;
            if (unit_end_s) begin
                bit_cnt_d = 6'd0;
            end else if (phase_q) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            phase_d   = 1'b0;
            bit_cnt_d = 6'd0;
        end

        if (((state_q == S_DATA) || (state_q == S_PAD)) && phase_q) begin
            crc_d = crc_step(crc_q, cur_bit_s);
        end else begin
            crc_d = crc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    byte_d     = bus.tx_data;
                    last_d     = bus.tx_last;
                    byte_cnt_d = 8'd1;
                    crc_d      = CRC_INIT;
                    state_d    = S_PREAMBLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREAMBLE: state_d = unit_end_s ? S_SFD : S_PREAMBLE;
            S_SFD:      state_d = unit_end_s ? S_DATA : S_SFD;
            S_DATA: begin
                if (!unit_end_s) begin
                    state_d = S_DATA;
                end else if (accept_s) begin
                    byte_d     = bus.tx_data;
                    last_d     = bus.tx_last;
                    byte_cnt_d = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
                end else if (last_q) begin
                    state_d = (byte_cnt_q < MIN_PAY) ? S_PAD : S_FCS;
                end else begin
                    underrun_d = 1'b1;
                    tp_cnt_d   = 16'd0;
                    state_d    = S_TPIDL;
                end
            end
            S_PAD: begin
                if (unit_end_s) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    state_d    = ((byte_cnt_q + 8'd1) >= MIN_PAY) ? S_FCS : S_PAD;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_FCS: begin
                if (unit_end_s) begin
                    tp_cnt_d = 16'd0;
                    state_d  = S_TPIDL;
                end else begin
                    state_d = S_FCS;
                end
            end
            S_TPIDL: begin
                if (tp_cnt_q == TPIDL_LAST) begin
                    ipg_cnt_d = IPG_LOAD;
                    state_d   = S_GAP;
                end else begin
                    tp_cnt_d = tp_cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                // Leaving on the count of 1 makes tx_ready rise exactly IPG_CYC clocks after TP_IDL.
                if (ipg_cnt_q <= 16'd1) begin
                    ipg_cnt_d = 16'd0;
                    state_d   = S_IDLE;
                end else begin
                    ipg_cnt_d = ipg_cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so line outputs come straight from flops.
    always_comb begin
        tx_w_d     = state_d inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_TPIDL};
        busy_d     = (state_d != S_IDLE);
        next_bit_s = line_bit(state_d, bit_cnt_d, byte_d, crc_d);
        if (state_d == S_TPIDL) begin
            eth_data_d = 1'b1;
        end else if (state_d inside {S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS}) begin
            eth_data_d = phase_d ? next_bit_s : ~next_bit_s;
        end else begin
            eth_data_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= 6'd0;
            byte_cnt_q <= 8'd0;
            byte_q     <= 8'd0;
            last_q     <= 1'b0;
            crc_q      <= CRC_INIT;
            tp_cnt_q   <= 16'd0;
            ipg_cnt_q  <= 16'd0;
            eth_data_q <= 1'b0;
            tx_w_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            crc_q      <= crc_d;
            tp_cnt_q   <= tp_cnt_d;
            ipg_cnt_q  <= ipg_cnt_d;
            eth_data_q <= eth_data_d;
            tx_w_q     <= tx_w_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end
endmodule
